aes_uart_block_sequencer: RTL and testbench
===========================================

// Module: aes_uart_block_sequencer
// PURPOSE
//  Sequences the UART->AES->UART datapath. Collects N_BYTES received UART bytes into one
//  block and launches the HLS AES core over its ap_ctrl_hs handshake. It then returns the
//  AES result byte-serially to the UART transmitter. Sits between uart_rx/uart_tx and the
//  HLS AES core, in the uart_clk domain.
// PARAMETERS
//  N_DATA_BITS    8        UART byte width
//  N_BYTES        16       bytes per AES block (128-bit)
//  TIMEOUT_CYCLES 1000000  i_clk cycles of rx silence that abandon a partial block; 0 = disabled
// PORTS
//  i_clk          in   1    uart_clk domain clock
//  i_reset        in   1    asynchronous, active-high reset
//  i_rx_data      in   8    received byte from uart_rx
//  i_rx_valid     in   1    level valid from uart_rx; the rising edge is detected internally
//  o_aes_din      out  128  block to AES; byte 0 in [127:120], byte 15 in [7:0]
//  o_aes_start    out  1    ap_start
//  i_aes_ready    in   1    ap_ready: the core has accepted its inputs
//  i_aes_done     in   1    ap_done, 1-cycle pulse
//  i_aes_dout     in   128  AES result, valid in the cycle i_aes_done=1
//  o_tx_data      out  8    byte to uart_tx
//  o_tx_valid     out  1    tx byte valid
//  i_tx_ready     in   1    uart_tx accepts the byte when o_tx_valid&&i_tx_ready
//  o_busy         out  1    1 in every state except COLLECT
//  o_rx_overrun   out  1    sticky: an rx byte arrived while not in COLLECT
//  o_block_count  out  16   blocks fully transmitted; wraps at 2^16
// BEHAVIOUR
//  Reset values: all outputs 0; state=COLLECT; byte index=0; edge-detect register=0.
//  rx event = i_rx_valid && !valid_q. Exactly one event per uart_rx valid pulse.
//  COLLECT
//   - Each rx event writes byte[idx], then idx++.
//   - The event with idx==N_BYTES-1 sets idx=0 and moves to START in the next cycle.
//   - The silence counter restarts on each event. It runs only while idx!=0.
//   - Reaching TIMEOUT_CYCLES sets idx=0 and discards the partial block. o_busy stays 0.
//  START
//   - o_aes_start=1 and o_aes_din is stable (registered).
//   - When i_aes_ready=1: drop start next cycle, go to WAIT_DONE.
//   - If i_aes_ready && i_aes_done arrive in the same cycle: capture dout, go directly to SEND.
//  WAIT_DONE
//   - On i_aes_done: capture i_aes_dout into the out-register, go to SEND.
//   - No timeout; the core is trusted to finish.
//  SEND
//   - o_tx_data = out-byte[k], starting at k=0 ([127:120]). o_tx_valid=1.
//   - Each accepted handshake increments k. o_tx_data stays stable while valid && !ready.
//   - After byte N_BYTES-1 is accepted: o_tx_valid=0, o_block_count++, return to COLLECT
//     in the next cycle.
//  Rx handling outside COLLECT
//   - rx events in START/WAIT_DONE/SEND are dropped and set o_rx_overrun.
//   - The edge detector keeps running in all states, so a valid level spanning the return
//     to COLLECT is not re-counted.
//   - o_rx_overrun clears only on reset.
//  Latency, COLLECT->START: 1 cycle after the 16th rx event.
//  Latency, SEND: first byte is valid 1 cycle after ap_done.
//  Asserting i_reset at any point aborts immediately. Outstanding AES results are ignored;
//  an i_aes_done in COLLECT is ignored.
// STRUCTURE
//  Package aes_uart_pkg:
//   - typedef enum logic [1:0] {COLLECT, START, WAIT_DONE, SEND} seq_state_t
//   - typedef logic [127:0] aes_block_t
//   - localparam AES_BLOCK_BYTES=16
//  Sub-module byte_block_packer: serial<->parallel 16x8 register file with index and wrap.
//   - Instantiated twice: rx pack and tx unpack.
//  FSM, edge detect, timeout and counters stay in this module.
// TESTING
//  1. Send bytes 00..0F; ready=1 at the 2nd start cycle; done 20 cycles later with dout
//     = 0x69C4E0D86A7B0430D8CDB78070B4C55A.
//     -> o_aes_din=0x000102..0F; tx bytes 69,C4,..,5A in order; o_block_count=1.
//  2. i_tx_ready toggles 1/0 every cycle during SEND
//     -> each byte held stable while stalled; 16 bytes sent, none duplicated.
//  3. Send 5 bytes, then silence TIMEOUT_CYCLES (set to 100 in test), then 16 bytes AA
//     -> o_aes_din = all AA; no partial bytes in the block.
//  4. Send 3 bytes during WAIT_DONE -> o_rx_overrun=1; the next block collects cleanly
//     from idx 0.
//  5. i_aes_ready and i_aes_done in the same cycle -> SEND entered with no WAIT_DONE cycle;
//     o_aes_start low the next cycle.
//  6. Assert i_reset mid-SEND after byte 7 -> all outputs 0 asynchronously; a subsequent
//     block of 16 bytes completes normally.

Source files
------------

// File: rtl/aes_uart_pkg.sv
// aes_uart_pkg: shared types and constants for the UART/AES block sequencer
package aes_uart_pkg;
   typedef enum logic [1:0] {COLLECT, START, WAIT_DONE, SEND} seq_state_t;
   typedef logic [127:0] aes_block_t;
   localparam int AES_BLOCK_BYTES = 16;
endpackage

// File: rtl/aes_uart_block_sequencer_byte_block_packer.sv
// byte_block_packer: byte-serial <-> parallel block register with a wrapping byte index
module byte_block_packer
   import aes_uart_pkg::*;
#(
   parameter int W = 8,
   parameter int N = AES_BLOCK_BYTES,
   localparam int IW = N > 1 ? $clog2(N) : 1
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           clr_i,
   input  logic           wr_i,
   input  logic           adv_i,
   input  logic           ld_i,
   input  logic [W-1:0]   byte_i,
   input  logic [N*W-1:0] blk_i,
   output logic [N*W-1:0] blk_o,
   output logic [IW-1:0]  idx_o
);
   logic [W-1:0]  mem_q [N];
   logic [W-1:0]  mem_d [N];
   logic [IW-1:0] idx_q, idx_d;
   logic          last;
   assign idx_o = idx_q;
   assign last  = idx_q == IW'(N - 1);
   for (genvar g = 0; g < N; g++) begin : g_blk
      assign blk_o[(N-1-g)*W +: W] = mem_q[g];
   end
   // Parallel load or single-byte write at the index; index wraps after the last byte
   always_comb begin
      for (int i = 0; i < N; i++) mem_d[i] = ld_i ? blk_i[(N-1-i)*W +: W] : mem_q[i];
      if (wr_i) mem_d[idx_q] = byte_i;
      idx_d = (clr_i || ld_i) ? '0 : (wr_i || adv_i) ? (last ? '0 : idx_q + 1'b1) : idx_q;
   end
   // Byte storage and index registers
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         mem_q <= '{default: '0};
         idx_q <= '0;
      end else begin
         mem_q <= mem_d;
         idx_q <= idx_d;
      end
endmodule

// File: rtl/aes_uart_block_sequencer.sv
// aes_uart_block_sequencer: gathers UART bytes into an AES block, runs the core, streams the result back
module aes_uart_block_sequencer
   import aes_uart_pkg::*;
#(
   parameter int N_DATA_BITS    = 8,
   parameter int N_BYTES        = AES_BLOCK_BYTES,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                           i_clk,
   input  logic                           i_reset,
   input  logic [N_DATA_BITS-1:0]         i_rx_data,
   input  logic                           i_rx_valid,
   output logic [N_BYTES*N_DATA_BITS-1:0] o_aes_din,
   output logic                           o_aes_start,
   input  logic                           i_aes_ready,
   input  logic                           i_aes_done,
   input  logic [N_BYTES*N_DATA_BITS-1:0] i_aes_dout,
   output logic [N_DATA_BITS-1:0]         o_tx_data,
   output logic                           o_tx_valid,
   input  logic                           i_tx_ready,
   output logic                           o_busy,
   output logic                           o_rx_overrun,
   output logic [15:0]                    o_block_count
);
   localparam int IW = N_BYTES > 1 ? $clog2(N_BYTES) : 1;
   localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
   seq_state_t                          state_q, state_d;
   logic                                valid_q, overrun_q, overrun_d;
   logic [TW-1:0]                       timer_q, timer_d;
   logic [15:0]                         count_q, count_d;
   logic                                rx_ev, rx_wr, rx_last, timeout, tx_ld, tx_adv, tx_last;
   logic [IW-1:0]                       rx_idx, tx_idx, tx_sel;
   logic [N_BYTES-1:0][N_DATA_BITS-1:0] tx_blk;
   assign rx_ev     = i_rx_valid && !valid_q;
   assign rx_last   = rx_idx == IW'(N_BYTES - 1);
   assign tx_last   = tx_idx == IW'(N_BYTES - 1);
   assign tx_sel    = IW'(N_BYTES - 1) - tx_idx;
   assign timeout   = TIMEOUT_CYCLES != 0 && state_q == COLLECT && rx_idx != '0 && !rx_ev &&
                      timer_q == TW'(TIMEOUT_CYCLES - 1);
   assign timer_d   = (rx_ev || rx_idx == '0 || timeout || o_busy) ? '0 : timer_q + 1'b1;
   assign overrun_d = overrun_q || (rx_ev && o_busy);
   assign count_d   = count_q + 16'(tx_adv && tx_last);
   assign o_rx_overrun  = overrun_q;
   assign o_block_count = count_q;
   byte_block_packer #(.W(N_DATA_BITS), .N(N_BYTES)) u_rx_pack (
      .clk_i(i_clk), .rst_i(i_reset), .clr_i(timeout), .wr_i(rx_wr), .adv_i(1'b0), .ld_i(1'b0),
      .byte_i(i_rx_data), .blk_i('0), .blk_o(o_aes_din), .idx_o(rx_idx)
   );
   byte_block_packer #(.W(N_DATA_BITS), .N(N_BYTES)) u_tx_unpack (
      .clk_i(i_clk), .rst_i(i_reset), .clr_i(1'b0), .wr_i(1'b0), .adv_i(tx_adv), .ld_i(tx_ld),
      .byte_i('0), .blk_i(i_aes_dout), .blk_o(tx_blk), .idx_o(tx_idx)
   );
   // Sequencer state register
   always_ff @(posedge i_clk or posedge i_reset)
      if (i_reset) state_q <= COLLECT;
      else state_q <= state_d;
   // Next state: a ready+done coincidence in START skips WAIT_DONE
   always_comb begin
      state_d = state_q;
      case (state_q)
         COLLECT:   if (rx_ev && rx_last) state_d = START;
         START:     if (i_aes_ready) state_d = i_aes_done ? SEND : WAIT_DONE;
         WAIT_DONE: if (i_aes_done) state_d = SEND;
         SEND:      if (tx_adv && tx_last) state_d = COLLECT;
         default:   state_d = COLLECT;
      endcase
   end
   // State-decoded outputs and datapath strobes; done outside START/WAIT_DONE is ignored
   always_comb begin
      o_aes_start = state_q == START;
      o_tx_valid  = state_q == SEND;
      o_busy      = state_q != COLLECT;
      o_tx_data   = o_tx_valid ? tx_blk[tx_sel] : '0;
      rx_wr       = rx_ev && state_q == COLLECT;
      tx_ld       = i_aes_done && (state_q == WAIT_DONE || (o_aes_start && i_aes_ready));
      tx_adv      = o_tx_valid && i_tx_ready;
   end
   // Rx edge detect (runs in every state), silence timer, sticky overrun and block counter
   always_ff @(posedge i_clk or posedge i_reset)
      if (i_reset) begin
         valid_q   <= 1'b0;
         timer_q   <= '0;
         overrun_q <= 1'b0;
         count_q   <= '0;
      end else begin
         valid_q   <= i_rx_valid;
         timer_q   <= timer_d;
         overrun_q <= overrun_d;
         count_q   <= count_d;
      end
endmodule

// File: tb/tb_aes_uart_block_sequencer.sv
// tb_aes_uart_block_sequencer: directed scoreboard test of the UART/AES block sequencer
module tb_aes_uart_block_sequencer;
   import aes_uart_pkg::*;
   localparam int TO = 100;
   logic         i_clk = 1'b0;
   logic         i_reset, i_rx_valid, i_aes_ready, i_aes_done, i_tx_ready;
   logic [7:0]   i_rx_data;
   aes_block_t   i_aes_dout;
   aes_block_t   o_aes_din;
   logic         o_aes_start, o_tx_valid, o_busy, o_rx_overrun;
   logic [7:0]   o_tx_data;
   logic [15:0]  o_block_count;
   int           checks = 0, errors = 0, tx_cnt = 0, blk_exp = 0;
   logic [7:0]   exp_q [$];
   bit           hold_chk = 1'b0;
   logic [7:0]   hold_d = '0;
   aes_block_t   blk;

   always #5 i_clk = ~i_clk;

   aes_uart_block_sequencer #(.N_DATA_BITS(8), .N_BYTES(16), .TIMEOUT_CYCLES(TO)) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
      .o_aes_din(o_aes_din), .o_aes_start(o_aes_start), .i_aes_ready(i_aes_ready),
      .i_aes_done(i_aes_done), .i_aes_dout(i_aes_dout), .o_tx_data(o_tx_data),
      .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready), .o_busy(o_busy),
      .o_rx_overrun(o_rx_overrun), .o_block_count(o_block_count)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, want);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_din"}, o_aes_din, '0);
      check({tag, "_ctl"}, {o_aes_start, o_tx_data, o_tx_valid, o_busy, o_rx_overrun, o_block_count}, '0);
   endtask

   // One clock: tx monitor at the falling edge, then return 1 time unit after the rising edge
   task automatic step();
      @(negedge i_clk);
      if (hold_chk) check("tx_hold", {o_tx_valid, o_tx_data}, {1'b1, hold_d});
      if (o_tx_valid && i_tx_ready) begin
         check("tx_expected", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) check("tx_byte", o_tx_data, exp_q.pop_front());
         tx_cnt++;
      end
      hold_chk = o_tx_valid && !i_tx_ready;
      hold_d = o_tx_data;
      @(posedge i_clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      i_rx_data = b;
      i_rx_valid = 1'b1;
      step();
      step();
      i_rx_valid = 1'b0;
      step();
      step();
   endtask

   task automatic send_bytes(input logic [7:0] b0, input logic [7:0] inc, input int n, output aes_block_t bb);
      logic [7:0] b;
      bb = '0;
      for (int i = 0; i < n; i++) begin
         b = b0 + inc * 8'(i);
         send_byte(b);
         bb = {bb[119:0], b};
      end
   endtask

   task automatic push_exp(input aes_block_t d);
      for (int i = 0; i < 16; i++) exp_q.push_back(d[127-8*i -: 8]);
   endtask

   task automatic run_send(input bit tog, input int stop_at);
      int base = tx_cnt;
      for (int n = 0; n < 100; n++) begin
         step();
         if (tog) i_tx_ready = !i_tx_ready;
         if (stop_at != 0 && tx_cnt - base == stop_at) return;
         if (!o_busy) break;
      end
      blk_exp++;
      check("send_done", o_busy, 0);
      check("tx_all_sent", tx_cnt - base, 16);
      check("block_count", o_block_count, blk_exp);
   endtask

   task automatic aes_block(input aes_block_t din_exp, input aes_block_t dout, input bit same,
                            input int n_ovr, input bit tog, input int stop_at);
      int n = 0;
      while (!o_aes_start && n < 50) begin
         step();
         n++;
      end
      check("start_seen", o_aes_start, 1);
      check("aes_din", o_aes_din, din_exp);
      i_tx_ready = 1'b1;
      if (same) begin
         i_aes_ready = 1'b1;
         i_aes_done = 1'b1;
         i_aes_dout = dout;
         push_exp(dout);
         step();
         i_aes_ready = 1'b0;
         i_aes_done = 1'b0;
         check("start_drop", o_aes_start, 0);
      end else begin
         step();
         check("start_hold", o_aes_start, 1);
         i_aes_ready = 1'b1;
         step();
         i_aes_ready = 1'b0;
         check("start_drop", o_aes_start, 0);
         check("wait_busy", {o_busy, o_tx_valid}, 2'b10);
         for (int i = 0; i < n_ovr; i++) send_byte(8'hE0 + 8'(i));
         repeat (19) step();
         i_aes_done = 1'b1;
         i_aes_dout = dout;
         push_exp(dout);
         step();
         i_aes_done = 1'b0;
      end
      check("send_latency", o_tx_valid, 1);
      check("first_byte", o_tx_data, dout[127:120]);
      run_send(tog, stop_at);
   endtask

   initial begin
      i_reset = 1'b1;
      i_rx_valid = 1'b0;
      i_rx_data = '0;
      i_aes_ready = 1'b0;
      i_aes_done = 1'b0;
      i_aes_dout = '0;
      i_tx_ready = 1'b1;
      step();
      step();
      check_zero("reset");
      i_reset = 1'b0;
      step();
      // 1: basic block 00..0F with known AES result
      send_bytes(8'h00, 8'h01, 15, blk);
      i_rx_data = 8'h0F;
      i_rx_valid = 1'b1;
      check("pre_start_busy", o_busy, 0);
      step();
      check("start_latency", o_aes_start, 1);
      i_rx_valid = 1'b0;
      aes_block(128'h000102030405060708090A0B0C0D0E0F, 128'h69C4E0D86A7B0430D8CDB78070B4C55A, 0, 0, 0, 0);
      // 2: tx ready toggling every cycle
      send_bytes(8'h03, 8'h07, 16, blk);
      aes_block(blk, 128'h00112233445566778899AABBCCDDEEFF, 0, 0, 1, 0);
      // 3: partial block abandoned by silence timeout
      send_bytes(8'h11, 8'h01, 5, blk);
      repeat (TO + 10) step();
      check("timeout_idle", o_busy, 0);
      send_bytes(8'hAA, 8'h00, 16, blk);
      aes_block({16{8'hAA}}, 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F, 0, 0, 0, 0);
      // 4: rx bytes during WAIT_DONE raise sticky overrun
      check("no_overrun", o_rx_overrun, 0);
      send_bytes(8'hC0, 8'h01, 16, blk);
      aes_block(blk, 128'h0123456789ABCDEFFEDCBA9876543210, 0, 3, 0, 0);
      check("overrun_set", o_rx_overrun, 1);
      // 5: next block collects from index 0; ready and done coincide
      send_bytes(8'h20, 8'h01, 16, blk);
      aes_block(blk, 128'h5A5AA5A5C3C33C3C0F0FF0F011223344, 1, 0, 0, 0);
      check("overrun_sticky", o_rx_overrun, 1);
      // 6: asynchronous reset mid-SEND after byte 7
      send_bytes(8'h30, 8'h01, 16, blk);
      aes_block(blk, 128'h8899AABBCCDDEEFF0011223344556677, 0, 0, 0, 8);
      i_reset = 1'b1;
      #1;
      check_zero("async_reset");
      check("flushed_bytes", exp_q.size(), 8);
      exp_q.delete();
      hold_chk = 1'b0;
      blk_exp = 0;
      step();
      i_reset = 1'b0;
      step();
      i_aes_done = 1'b1;
      i_aes_dout = 128'hDEADBEEFDEADBEEFDEADBEEFDEADBEEF;
      step();
      i_aes_done = 1'b0;
      check("done_in_collect", {o_busy, o_tx_valid}, 2'b00);
      send_bytes(8'h40, 8'h03, 16, blk);
      aes_block(blk, 128'h13579BDF2468ACE0FDB97531ECA86420, 0, 0, 0, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
